// File: rtl/ttpu_wb_pkg.sv
// Shared writeback types: FSM states, FIFO entry (lane data + mask) and a lane-scan helper.
// The entry is sized by WB_WIDTH/WB_NUM_UNITS, so the top's WIDTH/NUM_UNITS must match them.
package ttpu_wb_pkg;

  localparam int WB_WIDTH     = 16;
  localparam int WB_NUM_UNITS = 4;
  localparam int WB_LANE_W    = (WB_NUM_UNITS > 1) ? $clog2(WB_NUM_UNITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_FIN
  } wb_state_e;

  typedef struct packed {
    logic [WB_NUM_UNITS-1:0][WB_WIDTH-1:0] data;
    logic [WB_NUM_UNITS-1:0]               mask;
  } wb_entry_t;

  // Lowest set lane of mask at or above 'from'; the MSB of the result flags "found".
  function automatic logic [WB_LANE_W:0] next_lane(input logic [WB_NUM_UNITS-1:0] mask,
                                                  input logic [WB_LANE_W:0]      from);
    logic [WB_LANE_W:0] r;
    r = '0;
    for (int i = WB_NUM_UNITS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, WB_LANE_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Show-ahead synchronous FIFO (pop_dat is the head); full/empty are registered occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/result_writeback_unit.sv
// Queues result vectors and writes each active lane as one element per handshake; out_valid 3 cycles after data_ready.
// out_ready low freezes data/address; vectors arriving when full are dropped (sticky overflow); RESULT_WB_STATS_EN adds wr_count.
module result_writeback_unit
  import ttpu_wb_pkg::*;
#(
  parameter int WIDTH     = WB_WIDTH,
  parameter int NUM_UNITS = WB_NUM_UNITS,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            data_ready,
  input  logic [NUM_UNITS-1:0][WIDTH-1:0] relu_out,
  input  logic [NUM_UNITS-1:0]            active_units,
  input  logic                            addr_load,
  input  logic [ADDR_W-1:0]               base_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [ADDR_W-1:0]               out_addr,
  output logic                            full,
  output logic                            empty,
  output logic                            overflow,
  output logic                            vec_done,
  output logic                            busy
`ifdef RESULT_WB_STATS_EN
  ,
  output logic [15:0]                     wr_count
`endif
);

  wb_state_e            state_q, state_d;
  wb_entry_t            hold_q, hold_d;
  logic [WB_LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 ovf_q, ovf_d;

  wb_entry_t               push_ent, pop_ent;
  logic [$bits(wb_entry_t)-1:0] pop_raw;
  logic                    pop, hs;
  logic [WB_LANE_W:0]      first_l, after_l;

  assign push_ent = {relu_out, active_units};
  assign pop_ent  = wb_entry_t'(pop_raw);
  assign pop      = (state_q == ST_LOAD);

  wb_fifo #(
    .W     ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (data_ready),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (pop_raw),
    .full     (full),
    .empty    (empty)
  );

  assign out_valid = (state_q == ST_SEND);
  assign hs        = out_valid && out_ready;
  assign out_data  = hold_q.data[lane_q];
  assign out_addr  = addr_q;
  assign overflow  = ovf_q;
  assign vec_done  = (state_q == ST_FIN);
  assign busy      = (state_q != ST_IDLE);

  assign first_l = next_lane(pop_ent.mask, '0);
  assign after_l = next_lane(hold_q.mask, {1'b0, lane_q} + 1'b1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lane_d  = lane_q;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_LOAD;
      ST_LOAD: begin
        hold_d  = pop_ent;
        lane_d  = first_l[WB_LANE_W-1:0];
        state_d = first_l[WB_LANE_W] ? ST_SEND : ST_FIN;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (after_l[WB_LANE_W]) lane_d = after_l[WB_LANE_W-1:0];
          else                    state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A load overrides the increment; the element handshaking this cycle still used addr_q.
  always_comb begin
    addr_d = addr_q;
    if (hs)        addr_d = addr_q + 1'b1;
    if (addr_load) addr_d = base_addr;
    ovf_d = ovf_q | (data_ready && full && !pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef RESULT_WB_STATS_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (hs && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule
